spi_word_feeder: RTL

SPI_WORD_FEEDER -- requirements
Module: spi_word_feeder

---
 rtl/spi_word_feeder_if.sv | 37 +++
 rtl/spi_word_feeder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/spi_word_feeder_if.sv
// Bus bundle for spi_word_feeder: command-FIFO write side, SPI master side and status.
// slave = the feeder itself, master = whatever drives it.
interface spi_word_feeder_if #(
    parameter int WORD_W = 18,
    parameter int DEPTH  = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WORD_W-1:0] i_Wr_Word;
    logic              i_Wr_En;
    logic              o_Full;
    logic              o_Empty;
    logic [LW-1:0]     o_Level;
    logic [WORD_W-1:0] o_TX_Byte;
    logic              o_TX_DV;
    logic              i_TX_Ready;
    logic              i_RX_DV;
    logic [WORD_W-1:0] i_RX_Byte;
    logic [WORD_W-1:0] o_Rd_Word;
    logic              o_Rd_Valid;
    logic              o_Busy;
    logic              o_Ovf;
    logic              o_Timeout;
    logic              i_Clr_Err;

    modport slave (
        input  i_Wr_Word, i_Wr_En, i_TX_Ready, i_RX_DV, i_RX_Byte, i_Clr_Err,
        output o_Full, o_Empty, o_Level, o_TX_Byte, o_TX_DV, o_Rd_Word, o_Rd_Valid,
               o_Busy, o_Ovf, o_Timeout
    );

    modport master (
        output i_Wr_Word, i_Wr_En, i_TX_Ready, i_RX_DV, i_RX_Byte, i_Clr_Err,
        input  o_Full, o_Empty, o_Level, o_TX_Byte, o_TX_DV, o_Rd_Word, o_Rd_Valid,
               o_Busy, o_Ovf, o_Timeout
    );
endinterface

// File: rtl/spi_word_feeder.sv
// Queues words in a circular FIFO and feeds them one at a time to an SPI master,
// capturing each reply, enforcing an inter-transfer gap and a reply timeout.
module spi_word_feeder #(
    parameter int WORD_W       = 18,
    parameter int DEPTH        = 8,
    parameter int GAP_CLKS     = 4,
    parameter int TIMEOUT_CLKS = 1024
) (
    input logic              i_Clk,
    input logic              i_Rst_L,
    spi_word_feeder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam int GW = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;
    localparam logic [AW:0]   FULL_LVL = DEPTH[AW:0];
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RX, GAP} state_t;

    state_t            state_q;
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic              full_q, empty_q;
    logic              tx_dv_q, rd_valid_q, busy_q, ovf_q, tmo_q;
    logic [WORD_W-1:0] tx_byte_q, rd_word_q;
    logic [TW-1:0]     tmo_cnt_q;
    logic [GW-1:0]     gap_cnt_q;
    logic              push, pop, tmo_evt, ovf_evt;

    // The head is popped on the same edge that enters ISSUE, so o_TX_DV lines up with the pop.
    assign push    = i_Rst_L && bus.i_Wr_En && !full_q;
    assign pop     = (state_q == IDLE) && !empty_q && bus.i_TX_Ready;
    assign ovf_evt = bus.i_Wr_En && full_q;
    assign tmo_evt = (state_q == WAIT_RX) && !bus.i_RX_DV && (tmo_cnt_q == TMO_LAST);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.i_Wr_Word;
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= (level_d == FULL_LVL);
            empty_q  <= (level_d == '0);
            // A fresh error event wins over a simultaneous clear.
            ovf_q    <= ovf_evt || (ovf_q && !bus.i_Clr_Err);
            tmo_q    <= tmo_evt || (tmo_q && !bus.i_Clr_Err);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q    <= IDLE;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_word_q  <= '0;
            busy_q     <= 1'b0;
            tmo_cnt_q  <= '0;
            gap_cnt_q  <= '0;
        end else begin
            tx_dv_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q   <= ISSUE;
                        tx_dv_q   <= 1'b1;
                        tx_byte_q <= mem_q[rd_ptr_q];
                        busy_q    <= 1'b1;
                    end
                end
                ISSUE: begin
                    state_q   <= WAIT_RX;
                    tmo_cnt_q <= '0;
                end
                WAIT_RX: begin
                    if (bus.i_RX_DV) begin
                        rd_word_q  <= bus.i_RX_Byte;
                        rd_valid_q <= 1'b1;
                        if (GAP_CLKS == 0) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= GAP;
                            gap_cnt_q <= GW'(GAP_CLKS);
                        end
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == GW'(1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_Full     = full_q;
    assign bus.o_Empty    = empty_q;
    assign bus.o_Level    = level_q;
    assign bus.o_TX_Byte  = tx_byte_q;
    assign bus.o_TX_DV    = tx_dv_q;
    assign bus.o_Rd_Word  = rd_word_q;
    assign bus.o_Rd_Valid = rd_valid_q;
    assign bus.o_Busy     = busy_q;
    assign bus.o_Ovf      = ovf_q;
    assign bus.o_Timeout  = tmo_q;
endmodule
